// File: rtl/result_writeback_unit.sv
// ============================================================================
// Module   : result_writeback_unit
// Brief    : Round-robin merge of integer ALU and FPU results into a single
//            registered register-file write port. WB_FFLAGS_EN adds sticky
//            {exc,ovf,unf} flag accumulation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_valid,
    output logic        int_ready,
    input  logic [31:0] int_result,
    input  logic [4:0]  int_rd,
    input  logic        fpu_valid,
    output logic        fpu_ready,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_rd,
    input  logic        fpu_dest_int,
    input  logic        fpu_exc,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_is_fp,
    output logic [2:0]  fflags,
    input  logic        fflags_clr
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_INT_W  = 37;
`ifdef WB_FFLAGS_EN
    localparam int c_FPU_W  = 41;
`else
    localparam int c_FPU_W  = 38;
`endif

    // Integer FIFO: {result, rd}; is_fp is implicitly 0
    logic [c_INT_W-1:0]  r_int_mem [DEPTH];
    logic [c_ADDR_W:0]   r_int_wptr, r_int_rptr;
    logic [c_FPU_W-1:0]  r_fpu_mem [DEPTH];
    logic [c_ADDR_W:0]   r_fpu_wptr, r_fpu_rptr;

    logic w_int_empty, w_int_full, w_fpu_empty, w_fpu_full;
    logic w_int_push, w_fpu_push;
    logic w_load_en, w_grant_int, w_grant_fpu, w_discard;
    logic [c_INT_W-1:0] w_int_head;
    logic [c_FPU_W-1:0] w_fpu_head, w_fpu_entry;
    logic [31:0] w_sel_data;
    logic [4:0]  w_sel_rd;
    logic        w_sel_is_fp;
    logic [2:0]  w_sel_flags;

    logic        r_wb_valid, r_wb_is_fp, r_last_grant_fpu;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic [2:0]  r_wb_flags;

    assign w_int_empty = (r_int_wptr == r_int_rptr);
    assign w_int_full  = (r_int_wptr[c_ADDR_W] != r_int_rptr[c_ADDR_W]) &&
                         (r_int_wptr[c_ADDR_W-1:0] == r_int_rptr[c_ADDR_W-1:0]);
    assign w_fpu_empty = (r_fpu_wptr == r_fpu_rptr);
    assign w_fpu_full  = (r_fpu_wptr[c_ADDR_W] != r_fpu_rptr[c_ADDR_W]) &&
                         (r_fpu_wptr[c_ADDR_W-1:0] == r_fpu_rptr[c_ADDR_W-1:0]);

    assign int_ready  = !w_int_full && !rst;
    assign fpu_ready  = !w_fpu_full && !rst;
    assign w_int_push = int_valid && int_ready;
    assign w_fpu_push = fpu_valid && fpu_ready;

`ifdef WB_FFLAGS_EN
    assign w_fpu_entry = {fpu_result, fpu_rd, ~fpu_dest_int, fpu_exc, fpu_ovf, fpu_unf};
`else
    assign w_fpu_entry = {fpu_result, fpu_rd, ~fpu_dest_int};
`endif

    assign w_int_head = r_int_mem[r_int_rptr[c_ADDR_W-1:0]];
    assign w_fpu_head = r_fpu_mem[r_fpu_rptr[c_ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_int_push) r_int_mem[r_int_wptr[c_ADDR_W-1:0]] <= {int_result, int_rd};
        if (w_fpu_push) r_fpu_mem[r_fpu_wptr[c_ADDR_W-1:0]] <= w_fpu_entry;
    end

    assign w_load_en = !r_wb_valid || wb_ready;

    always_comb begin
        w_grant_int = 1'b0;
        w_grant_fpu = 1'b0;
        if (w_load_en) begin
            if (!w_int_empty && !w_fpu_empty) begin
                w_grant_int = r_last_grant_fpu;
                w_grant_fpu = !r_last_grant_fpu;
            end else if (!w_int_empty) begin
                w_grant_int = 1'b1;
            end else if (!w_fpu_empty) begin
                w_grant_fpu = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_data  = w_int_head[36:5];
        w_sel_rd    = w_int_head[4:0];
        w_sel_is_fp = 1'b0;
        w_sel_flags = 3'b000;
        if (w_grant_fpu) begin
            w_sel_data  = w_fpu_head[c_FPU_W-1 -: 32];
            w_sel_rd    = w_fpu_head[c_FPU_W-33 -: 5];
            w_sel_is_fp = w_fpu_head[c_FPU_W-38];
`ifdef WB_FFLAGS_EN
            w_sel_flags = w_fpu_head[2:0];
`endif
        end
    end

    // Integer-file writes to x0 are dropped at grant time
    assign w_discard = !w_sel_is_fp && (w_sel_rd == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_wptr       <= '0;
            r_int_rptr       <= '0;
            r_fpu_wptr       <= '0;
            r_fpu_rptr       <= '0;
            r_last_grant_fpu <= 1'b1;
            r_wb_valid       <= 1'b0;
            r_wb_data        <= 32'd0;
            r_wb_rd          <= 5'd0;
            r_wb_is_fp       <= 1'b0;
            r_wb_flags       <= 3'b000;
        end else begin
            if (w_int_push)  r_int_wptr <= r_int_wptr + 1'b1;
            if (w_fpu_push)  r_fpu_wptr <= r_fpu_wptr + 1'b1;
            if (w_grant_int) r_int_rptr <= r_int_rptr + 1'b1;
            if (w_grant_fpu) r_fpu_rptr <= r_fpu_rptr + 1'b1;
            if (w_grant_int || w_grant_fpu) r_last_grant_fpu <= w_grant_fpu;
            if (w_load_en) begin
                if ((w_grant_int || w_grant_fpu) && !w_discard) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_sel_data;
                    r_wb_rd    <= w_sel_rd;
                    r_wb_is_fp <= w_sel_is_fp;
                    r_wb_flags <= w_sel_flags;
                end else begin
                    r_wb_valid <= 1'b0;
                end
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_data;
    assign wb_rd    = r_wb_rd;
    assign wb_is_fp = r_wb_is_fp;

`ifdef WB_FFLAGS_EN
    logic [2:0] r_fflags;

    // Flags delivered this cycle are OR-ed after the clear so they survive it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fflags <= 3'b000;
        end else begin
            r_fflags <= (fflags_clr ? 3'b000 : r_fflags) |
                        ((r_wb_valid && wb_ready) ? r_wb_flags : 3'b000);
        end
    end

    assign fflags = r_fflags;
`else
    logic w_unused_flag_inputs;

    assign w_unused_flag_inputs = ^{fflags_clr, fpu_exc, fpu_ovf, fpu_unf, r_wb_flags};
    assign fflags = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_writeback_unit.sv
// ============================================================================
// Module   : tb_result_writeback_unit
// Brief    : Self-checking bench for result_writeback_unit (scoreboard queue).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_valid = 1'b0, fpu_valid = 1'b0;
    logic        int_ready, fpu_ready;
    logic [31:0] int_result = '0, fpu_result = '0;
    logic [4:0]  int_rd = '0, fpu_rd = '0;
    logic        fpu_dest_int = 1'b0, fpu_exc = 1'b0, fpu_ovf = 1'b0, fpu_unf = 1'b0;
    logic        wb_valid, wb_is_fp;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [2:0]  fflags;
    logic        fflags_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_fp;
    } exp_t;

    typedef struct {
        logic        is_fpu;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        dest_int;
        logic        exp_write;
        logic        exp_is_fp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];

`ifdef WB_FFLAGS_EN
    localparam logic [2:0] c_FLAG_OVF = 3'b010;
    localparam logic [2:0] c_FLAG_UNF = 3'b001;
`else
    localparam logic [2:0] c_FLAG_OVF = 3'b000;
    localparam logic [2:0] c_FLAG_UNF = 3'b000;
`endif

    result_writeback_unit #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .int_valid(int_valid), .int_ready(int_ready),
        .int_result(int_result), .int_rd(int_rd),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_result(fpu_result), .fpu_rd(fpu_rd), .fpu_dest_int(fpu_dest_int),
        .fpu_exc(fpu_exc), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_is_fp(wb_is_fp),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Every completed write is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got data=%h rd=%0d fp=%0b, want no write",
                         wb_data, wb_rd, wb_is_fp);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wb_data !== e.data || wb_rd !== e.rd || wb_is_fp !== e.is_fp) begin
                    errors++;
                    $display("FAIL wb_out: got data=%h rd=%0d fp=%0b, want data=%h rd=%0d fp=%0b",
                             wb_data, wb_rd, wb_is_fp, e.data, e.rd, e.is_fp);
                end
            end
        end
    end

    task automatic expect_wr(input logic [31:0] d, input logic [4:0] rd, input logic fp);
        exp_t e;
        e.data = d; e.rd = rd; e.is_fp = fp;
        exp_q.push_back(e);
    endtask

    task automatic push_int(input logic [31:0] d, input logic [4:0] rd);
        int n;
        int_valid = 1'b1; int_result = d; int_rd = rd;
        n = 0;
        do begin @(negedge clk); n++; end while (!int_ready && n < 200);
        if (!int_ready) begin
            checks++; errors++;
            $display("FAIL int_push_timeout: got ready=0, want ready=1");
        end
        @(posedge clk); #1;
        int_valid = 1'b0;
    endtask

    task automatic push_fpu(input logic [31:0] d, input logic [4:0] rd,
                            input logic dest_int, input logic [2:0] flg);
        int n;
        fpu_valid = 1'b1; fpu_result = d; fpu_rd = rd; fpu_dest_int = dest_int;
        {fpu_exc, fpu_ovf, fpu_unf} = flg;
        n = 0;
        do begin @(negedge clk); n++; end while (!fpu_ready && n < 200);
        if (!fpu_ready) begin
            checks++; errors++;
            $display("FAIL fpu_push_timeout: got ready=0, want ready=1");
        end
        @(posedge clk); #1;
        fpu_valid = 1'b0;
        {fpu_exc, fpu_ovf, fpu_unf} = 3'b000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_00AA, 5'd5,  1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_1234, 5'd0,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h3F80_0000, 5'd0,  1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'hC000_0000, 5'd0,  1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0001, 5'd9,  1'b1, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        chk("ready_in_reset", {30'd0, int_ready, fpu_ready}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_fields", {wb_data ^ {26'd0, wb_rd, wb_is_fp}}, 32'd0);
        chk("rst_fflags", {29'd0, fflags}, 32'd0);
        chk("rst_readies", {30'd0, int_ready, fpu_ready}, 32'd3);

        // Contended streams alternate, integer first after reset
        @(posedge clk); #1;
        expect_wr(32'd1, 5'd1, 1'b0); expect_wr(32'h3F80_0000, 5'd1, 1'b1);
        expect_wr(32'd2, 5'd2, 1'b0); expect_wr(32'h4000_0000, 5'd2, 1'b1);
        expect_wr(32'd3, 5'd3, 1'b0); expect_wr(32'h4040_0000, 5'd3, 1'b1);
        fork
            begin push_int(32'd1, 5'd1); push_int(32'd2, 5'd2); push_int(32'd3, 5'd3); end
            begin
                push_fpu(32'h3F80_0000, 5'd1, 1'b0, 3'b000);
                push_fpu(32'h4000_0000, 5'd2, 1'b0, 3'b000);
                push_fpu(32'h4040_0000, 5'd3, 1'b0, 3'b000);
            end
        join
        drain();

        // Single-result vectors, including x0 discards
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vecs[i].exp_write) expect_wr(vecs[i].data, vecs[i].rd, vecs[i].exp_is_fp);
            if (vecs[i].is_fpu) push_fpu(vecs[i].data, vecs[i].rd, vecs[i].dest_int, 3'b000);
            else                push_int(vecs[i].data, vecs[i].rd);
            drain();
            chk($sformatf("vec%0d_idle", i), {31'd0, wb_valid}, 32'd0);
        end

        // rd=0 integer write dropped, following rd=7 write kept
        @(posedge clk); #1;
        expect_wr(32'h0000_0077, 5'd7, 1'b0);
        push_int(32'h0000_0066, 5'd0);
        push_int(32'h0000_0077, 5'd7);
        drain();

        // Back-pressure: two queued plus one held, then ordered drain
        @(posedge clk); #1 wb_ready = 1'b0;
        expect_wr(32'd11, 5'd4, 1'b0); expect_wr(32'd12, 5'd4, 1'b0); expect_wr(32'd13, 5'd4, 1'b0);
        push_int(32'd11, 5'd4); push_int(32'd12, 5'd4); push_int(32'd13, 5'd4);
        @(negedge clk);
        chk("bp_int_ready_low", {31'd0, int_ready}, 32'd0);
        chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_wb_data_stable", wb_data, 32'd11);
        @(posedge clk); #1 wb_ready = 1'b1;
        drain();

        // Sticky flags: ovf delivered, then unf delivered together with a clear
        @(posedge clk); #1;
        expect_wr(32'h7F80_0000, 5'd2, 1'b1);
        push_fpu(32'h7F80_0000, 5'd2, 1'b0, 3'b010);
        drain();
        chk("fflags_ovf", {29'd0, fflags}, {29'd0, c_FLAG_OVF});
        @(posedge clk); #1 wb_ready = 1'b0;
        expect_wr(32'h0000_0002, 5'd3, 1'b1);
        push_fpu(32'h0000_0002, 5'd3, 1'b0, 3'b001);
        begin
            int n;
            n = 0;
            while (!wb_valid && n < 50) begin @(negedge clk); n++; end
        end
        chk("flag_result_held", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1 wb_ready = 1'b1; fflags_clr = 1'b1;
        @(posedge clk); #1 fflags_clr = 1'b0;
        @(negedge clk);
        chk("fflags_unf_survives_clr", {29'd0, fflags}, {29'd0, c_FLAG_UNF});
        drain();

        // Fill both FIFOs with output held, then reset mid-transfer
        @(posedge clk); #1 wb_ready = 1'b0;
        fork
            begin push_int(32'd21, 5'd1); push_int(32'd22, 5'd1); push_int(32'd23, 5'd1); end
            begin push_fpu(32'd31, 5'd1, 1'b0, 3'b100); push_fpu(32'd32, 5'd1, 1'b0, 3'b100); end
        join
        @(negedge clk);
        chk("full_readies_low", {30'd0, int_ready, fpu_ready}, 32'd0);
        chk("full_wb_valid", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("post_rst_readies", {30'd0, int_ready, fpu_ready}, 32'd3);
        chk("post_rst_fflags", {29'd0, fflags}, 32'd0);
        chk("post_rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1 wb_ready = 1'b1;
        repeat (5) @(negedge clk);

        // First contended grant after reset goes to integer
        @(posedge clk); #1;
        expect_wr(32'h11, 5'd1, 1'b0); expect_wr(32'h22, 5'd2, 1'b1);
        fork
            push_int(32'h11, 5'd1);
            push_fpu(32'h22, 5'd2, 1'b0, 3'b000);
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_writeback_unit.md
RESULT_WRITEBACK_UNIT -- requirements
Module: result_writeback_unit

Interface
REQ-001 Parameter DEPTH, default 2, per-source result FIFO depth; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 int_valid/int_ready  input/output  1/1  integer ALU result handshake.
REQ-005 int_result  input  32  integer ALU result; int_rd  input  5  destination register.
REQ-006 fpu_valid/fpu_ready  input/output  1/1  FPU result handshake.
REQ-007 fpu_result  input  32  FPU result; fpu_rd  input  5  destination register.
REQ-008 fpu_dest_int  input  1  FPU result targets the integer file (compare/convert ops).
REQ-009 fpu_exc, fpu_ovf, fpu_unf  input  1 each  FPU Exception, Overflow and Underflow flags for the result.
REQ-010 wb_valid/wb_ready  output/input  1/1  register-file write handshake.
REQ-011 wb_data  output  32; wb_rd  output  5; wb_is_fp  output  1  write data, target register, float-file select.
REQ-012 fflags  output  3  sticky {exc,ovf,unf}; fflags_clr  input  1  clears the sticky flags.

Function
REQ-013 Each source SHALL own a DEPTH-entry FIFO; int entries store {result,rd,is_fp=0}; FPU entries store {result,rd,is_fp=~fpu_dest_int,exc,ovf,unf}.
REQ-014 A push SHALL occur on x_valid && x_ready; x_ready SHALL equal FIFO-not-full, with no same-cycle pop pass-through (full => ready low even while popping).
REQ-015 The output register SHALL load when (!wb_valid || wb_ready) and at least one FIFO holds an entry; wb_* SHALL hold stable while wb_valid && !wb_ready.
REQ-016 Arbitration SHALL be round-robin: if both FIFOs are non-empty, grant the source not granted last; if one is non-empty, grant it; last_grant updates only on a grant.
REQ-017 Latency: an entry pushed at edge k SHALL appear with wb_valid high no earlier than after edge k+1; no input-to-output bypass.
REQ-018 An entry with is_fp=0 and rd=0 SHALL be popped and discarded at grant without asserting wb_valid; last_grant still updates.
REQ-019 Entries from one source SHALL leave in push order; no entry is ever dropped or duplicated except per REQ-018 or reset.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra pointer bit or occupancy count.
REQ-021 Simultaneous push and pop on the same FIFO (not full) SHALL keep occupancy unchanged.
REQ-022 wb_data, wb_rd and wb_is_fp SHALL be registered outputs; there is no combinational path from any input to wb_valid or wb_data.

Reset
REQ-023 rst SHALL empty both FIFOs, clear wb_valid, wb_data, wb_rd, wb_is_fp and fflags to 0, and set last_grant to FPU so the first contended grant goes to integer.
REQ-024 Reset asserted mid-transfer SHALL discard all queued and held results; int_ready and fpu_ready SHALL be 0 while rst is high.

Configuration
REQ-025 Macro WB_FFLAGS_EN SHALL select sticky-flag support.
REQ-026 With WB_FFLAGS_EN defined: when an FPU entry completes the wb handshake (wb_valid && wb_ready), fflags SHALL OR in its {exc,ovf,unf} at that edge; fflags_clr SHALL zero fflags; if both happen in the same cycle, the new flags SHALL survive the clear.
REQ-027 With WB_FFLAGS_EN undefined: fflags SHALL be constant 0, flag bits SHALL not be stored in the FIFO, and fflags_clr SHALL be ignored.

Verification
REQ-028 Single int push {0x0000_00AA, rd=5} with wb_ready=1 -> wb_valid high for one cycle with wb_data=0x0000_00AA, wb_rd=5, wb_is_fp=0.
REQ-029 Both sources push each cycle, int results 1,2,3 and FPU results 0x3F80_0000,0x4000_0000,0x4040_0000 -> output order int1, fpu1, int2, fpu2, int3, fpu3.
REQ-030 wb_ready=0 while pushing 3 int results at DEPTH=2 -> int_ready low after 2 accepts plus 1 held in output; after wb_ready rises, all 3 drain in order.
REQ-031 Int push with rd=0 followed by rd=7 -> only the rd=7 write appears; the FPU push with rd=0 and is_fp=1 is written.
REQ-032 With WB_FFLAGS_EN, an FPU result with ovf=1 is delivered, then a result with unf=1 is delivered in the same cycle as fflags_clr=1 -> fflags=3'b010 then 3'b001.
REQ-033 Assert rst for one cycle with both FIFOs full and wb_valid high -> next cycle wb_valid=0, both readies=1 and fflags=0.
